// File: rtl/counter_target_ctrl.sv
// Walks an external up/down counter to a commanded target along the shortest wrap-around path,
// checking the counter readback every cycle and reporting done with a pass/fail flag per command.
module counter_target_ctrl #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  input  logic [WIDTH-1:0]     cmd_target,
  output logic                 cmd_ready,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     count_in,
  output logic                 mode,
  output logic                 pause,
  output logic                 busy,
  output logic                 done,
  output logic                 done_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  typedef enum logic [1:0] {IDLE, PLAN, RUN, CHECK} state_t;

  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

  state_t               state_q, state_d;
  logic                 mode_q, mode_d;
  logic                 pause_q, pause_d;
  logic                 done_q, done_d;
  logic                 done_err_q, done_err_d;
  logic                 trk_err_q, trk_err_d;
  logic [WIDTH-1:0]     target_q, target_d;
  logic [WIDTH-1:0]     expected_q, expected_d;
  logic [WIDTH-1:0]     remaining_q, remaining_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] steps;
  logic             active;
  logic             aborting;
  logic             trk_err_now;
  logic             final_err;

  // Modular distance decides direction; an exact half-circle tie goes up.
  assign diff        = target_q - count_in;
  assign steps       = (diff <= HALF) ? diff : ('0 - diff);
  assign active      = (state_q == RUN) || (state_q == CHECK);
  assign aborting    = abort && (state_q != IDLE);
  assign trk_err_now = trk_err_q | (active && (count_in != expected_q));
  assign final_err   = trk_err_now | (count_in != target_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = PLAN;
      PLAN:    state_d = (diff == '0) ? CHECK : RUN;
      RUN:     if (remaining_q == WIDTH'(1)) state_d = CHECK;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (aborting) state_d = IDLE;
  end

  always_comb begin
    mode_d      = mode_q;
    pause_d     = pause_q;
    done_d      = 1'b0;
    done_err_d  = 1'b0;
    trk_err_d   = trk_err_now;
    target_d    = target_q;
    expected_d  = expected_q;
    remaining_d = remaining_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      IDLE: begin
        pause_d = 1'b1;
        if (cmd_valid) begin
          target_d  = cmd_target;
          trk_err_d = 1'b0;
        end
      end
      PLAN: begin
        expected_d  = count_in;
        remaining_d = steps;
        if (diff != '0) begin
          mode_d  = (diff > HALF);
          pause_d = 1'b0;
        end
      end
      RUN: begin
        expected_d  = mode_q ? (expected_q - WIDTH'(1)) : (expected_q + WIDTH'(1));
        remaining_d = remaining_q - WIDTH'(1);
        if (remaining_q == WIDTH'(1)) pause_d = 1'b1;
      end
      CHECK: begin
        done_d     = 1'b1;
        done_err_d = final_err;
        if (final_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
      default: ;
    endcase
    // Aborts flag an error on done but are not charged to the failed-command counter.
    if (aborting) begin
      pause_d    = 1'b1;
      done_d     = 1'b1;
      done_err_d = 1'b1;
      err_cnt_d  = err_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= 1'b0;
      pause_q     <= 1'b1;
      done_q      <= 1'b0;
      done_err_q  <= 1'b0;
      trk_err_q   <= 1'b0;
      target_q    <= '0;
      expected_q  <= '0;
      remaining_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      mode_q      <= mode_d;
      pause_q     <= pause_d;
      done_q      <= done_d;
      done_err_q  <= done_err_d;
      trk_err_q   <= trk_err_d;
      target_q    <= target_d;
      expected_q  <= expected_d;
      remaining_q <= remaining_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    mode      = mode_q;
    pause     = pause_q;
    done      = done_q;
    done_err  = done_err_q;
    err_cnt   = err_cnt_q;
  end
endmodule

// File: tb/tb_counter_target_ctrl.sv
// Bench for counter_target_ctrl: a behavioural counter closes the loop, and a scoreboard
// queue holds the expected done/err/latency/final-count for each command driven.
module tb_counter_target_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [7:0] cmd_target;
  logic       cmd_ready;
  logic       abort;
  logic [7:0] count_in;
  logic       mode;
  logic       pause;
  logic       busy;
  logic       done;
  logic       done_err;
  logic [7:0] err_cnt;

  logic [7:0] cnt;
  logic       cnt_ld;
  logic [7:0] cnt_ld_dat;
  logic       glitch;

  typedef struct {
    int fin;
    int derr;
    int ecnt;
    int lat;
    int plo;
    int md;
  } exp_t;

  exp_t sb[$];
  int   n_cmp     = 0;
  int   n_bad     = 0;
  int   cyc       = 0;
  int   acc_cyc   = 0;
  int   pause_lo  = 0;
  int   err_model = 0;

  counter_target_ctrl #(.WIDTH(8), .ERR_CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_target (cmd_target),
    .cmd_ready  (cmd_ready),
    .abort      (abort),
    .count_in   (count_in),
    .mode       (mode),
    .pause      (pause),
    .busy       (busy),
    .done       (done),
    .done_err   (done_err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural up/down counter; glitch corrupts only the readback, not the count.
  always @(posedge clk) begin
    if (cnt_ld)      cnt <= cnt_ld_dat;
    else if (!pause) cnt <= mode ? cnt - 8'd1 : cnt + 8'd1;
  end
  assign count_in = cnt + {7'd0, glitch};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pause_lo = 0;
      end else begin
        if (!pause) pause_lo++;
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("done_err", int'(done_err), e.derr);
            chk("err_cnt", int'(err_cnt), e.ecnt);
            chk("final_count", int'(count_in), e.fin);
            chk("latency", cyc - acc_cyc, e.lat);
            chk("pause_low_cycles", pause_lo, e.plo);
            if (e.md >= 0) chk("mode", int'(mode), e.md);
          end
          pause_lo = 0;
        end
        if (cmd_valid && cmd_ready) acc_cyc = cyc + 1;
      end
    end
  end

  task automatic set_cnt(input logic [7:0] v);
    cnt_ld     = 1'b1;
    cnt_ld_dat = v;
    @(posedge clk); #1;
    cnt_ld     = 1'b0;
  endtask

  // g / a: RUN cycle (1-based) in which to glitch the readback / raise abort; 0 = never.
  task automatic do_cmd(input logic [7:0] tgt, input int g, input int a);
    exp_t       e;
    logic [7:0] diff;
    int         steps;
    int         md;
    int         i;
    logic       rdy;
    diff = tgt - cnt;
    if (diff == 8'd0) begin
      steps = 0;   md = -1;
    end else if (diff <= 8'd128) begin
      steps = int'(diff); md = 0;
    end else begin
      steps = 256 - int'(diff); md = 1;
    end
    e.md = md;
    if (a > 0) begin
      e.lat  = a + 1;
      e.plo  = a;
      e.derr = 1;
      e.ecnt = err_model;
      e.fin  = (md == 1) ? ((int'(cnt) - a) & 255) : ((int'(cnt) + a) & 255);
    end else begin
      e.lat  = steps + 2;
      e.plo  = steps;
      e.derr = (g > 0) ? 1 : 0;
      if (g > 0 && err_model < 255) err_model++;
      e.ecnt = err_model;
      e.fin  = int'(tgt);
    end
    sb.push_back(e);
    cmd_valid  = 1'b1;
    cmd_target = tgt;
    i = 0;
    do begin
      rdy = cmd_ready;
      @(posedge clk); #1;
      i++;
    end while (!rdy && i < 50);
    cmd_valid = 1'b0;
    if (!rdy) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    i = 1;
    while (!done && i < 400) begin
      glitch = (i == g);
      abort  = (i == a);
      @(posedge clk); #1;
      glitch = 1'b0;
      abort  = 1'b0;
      i++;
    end
    if (!done) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
  endtask

  initial begin
    logic [7:0] t;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_target = 8'd0;
    abort      = 1'b0;
    glitch     = 1'b0;
    cnt_ld     = 1'b1;
    cnt_ld_dat = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    cnt_ld = 1'b0;
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pause", int'(pause), 1);
    chk("rst_mode", int'(mode), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_done_err", int'(done_err), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_cmd(8'd5, 0, 0);
    set_cnt(8'd0);
    do_cmd(8'd250, 0, 0);
    set_cnt(8'd0);
    do_cmd(8'd128, 0, 0);
    set_cnt(8'd42);
    do_cmd(8'd42, 0, 0);
    set_cnt(8'd0);
    do_cmd(8'd10, 4, 0);
    do_cmd(8'd30, 0, 3);
    for (int k = 0; k < 6; k++) begin
      t = 8'($urandom_range(0, 255));
      do_cmd(t, 0, 0);
    end
    for (int k = 0; k < 256; k++) do_cmd(cnt + 8'd2, 1, 0);

    // Reset in the middle of a downward walk.
    cmd_valid  = 1'b1;
    cmd_target = cnt + 8'd200;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrun_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_pause", int'(pause), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_cmd_ready", int'(cmd_ready), 1);
    chk("midrst_err_cnt", int'(err_cnt), 0);
    chk("midrst_mode", int'(mode), 0);
    sb.delete();
    err_model = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_cmd(cnt - 8'd3, 0, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
